// File: rtl/mem_req_initiator.sv
// mem_req_initiator: MEM-stage load/store sequencer driving a doubleword data
// memory over a req/ack handshake. Applies byte strobes and lane shifts for
// stores, extracts and sign/zero-extends load data, and stalls the pipeline
// while an access is in flight.
// Optional feature: define MEM_MISALIGN_TRAP_EN to reject misaligned accesses
// with err=1 and no memory transaction. Without it, misaligned accesses proceed.
module mem_req_initiator #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] memory_address,
    input  logic [63:0] write_data,
    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] read_data,
    output logic        err,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wstrb,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    // Request fields needed after acceptance for load extraction
    logic [2:0]         r_off;
    logic [1:0]         r_size;
    logic               r_zext;

    logic               w_accept;
    logic               w_is_mem;
    logic [2:0]         w_in_off;
    logic [7:0]         w_strb_base;
    logic [7:0]         w_strb;
    logic [63:0]        w_wdata_sh;
    logic [63:0]        w_rd_sh;
    logic [63:0]        w_load_ext;
    logic [63:0]        w_rd_nxt;
    logic               w_err_nxt;
`ifdef MEM_MISALIGN_TRAP_EN
    logic               w_misalign;
`endif

    assign w_accept = (r_state == S_IDLE) & req_valid;
    assign w_is_mem = MemRead | MemWrite;
    assign w_in_off = memory_address[2:0];

    // Stall covers the acceptance cycle combinationally and every REQ cycle
    assign stall = reset_n & ((r_state == S_REQ) | ((r_state == S_IDLE) & req_valid));

    // Unshifted strobe mask for the access size
    always_comb begin
        w_strb_base = 8'h01;
        case (funct3[1:0])
            2'd0:    w_strb_base = 8'h01;
            2'd1:    w_strb_base = 8'h03;
            2'd2:    w_strb_base = 8'h0F;
            default: w_strb_base = 8'hFF;
        endcase
    end

    // Lane placement; bits shifted past the top of the doubleword are dropped
    assign w_strb     = w_strb_base << w_in_off;
    assign w_wdata_sh = write_data << {w_in_off, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
    // Offset must be a multiple of the access size
    always_comb begin
        w_misalign = 1'b0;
        case (funct3[1:0])
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = w_in_off[0];
            2'd2:    w_misalign = |w_in_off[1:0];
            default: w_misalign = |w_in_off;
        endcase
    end
`endif

    // Load data: align to bit 0 (zero fill from the top), then extend
    assign w_rd_sh = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = w_rd_sh;
        case (r_size)
            2'd0:    w_load_ext = r_zext ? {56'd0, w_rd_sh[7:0]}  : {{56{w_rd_sh[7]}},  w_rd_sh[7:0]};
            2'd1:    w_load_ext = r_zext ? {48'd0, w_rd_sh[15:0]} : {{48{w_rd_sh[15]}}, w_rd_sh[15:0]};
            2'd2:    w_load_ext = r_zext ? {32'd0, w_rd_sh[31:0]} : {{32{w_rd_sh[31]}}, w_rd_sh[31:0]};
            default: w_load_ext = w_rd_sh;
        endcase
    end

    // FSM state and timeout counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter and response payload
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rd_nxt    = '0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (req_valid) begin
                    if (!w_is_mem) begin
                        w_state_nxt = S_DONE;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (w_misalign) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                    end
`endif
                    else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // An ack on the expiry cycle still counts as success
                if (mem_ack) begin
                    w_state_nxt = S_DONE;
                    w_rd_nxt    = mem_we ? 64'd0 : w_load_ext;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs and latched request fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready  <= 1'b1;
            mem_req    <= 1'b0;
            resp_valid <= 1'b0;
            read_data  <= '0;
            err        <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_zext     <= 1'b0;
        end else begin
            req_ready  <= (w_state_nxt == S_IDLE);
            mem_req    <= (w_state_nxt == S_REQ);
            resp_valid <= (w_state_nxt == S_DONE);
            read_data  <= w_rd_nxt;
            err        <= w_err_nxt;
            if (w_accept) begin
                r_off  <= w_in_off;
                r_size <= funct3[1:0];
                r_zext <= funct3[2];
            end
            if (w_accept && (w_state_nxt == S_REQ)) begin
                mem_we    <= MemWrite;
                mem_addr  <= {memory_address[63:3], 3'b000};
                mem_wstrb <= MemWrite ? w_strb : 8'd0;
                mem_wdata <= MemWrite ? w_wdata_sh : 64'd0;
            end else if (w_state_nxt != S_REQ) begin
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wstrb <= '0;
                mem_wdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Self-checking bench for mem_req_initiator: transaction-level timeline model
// with per-cycle comparison, directed cases with literal expectations, and
// randomized load/store/no-op traffic.
module tb_mem_req_initiator;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [63:0] memory_address;
    logic [63:0] write_data;
    logic        stall;
    logic        resp_valid;
    logic [63:0] read_data;
    logic        err;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    mem_req_initiator #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .funct3         (funct3),
        .memory_address (memory_address),
        .write_data     (write_data),
        .stall          (stall),
        .resp_valid     (resp_valid),
        .read_data      (read_data),
        .err            (err),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wstrb      (mem_wstrb),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle
    logic        cmp_en = 1'b0;
    logic        e_ready, e_stall, e_req, e_resp, e_err, e_we;
    logic [63:0] e_rdata, e_addr, e_wdata;
    logic [7:0]  e_wstrb;
    int          cur_c;

    // Observations captured for literal checks after a transaction
    int          cap_req_cnt, cap_resp_c;
    logic        cap_err, cap_we;
    logic [63:0] cap_rd, cap_addr, cap_wdata;
    logic [7:0]  cap_wstrb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // Byte i is enabled when it lies inside [off, off+size) and below byte 8
    function automatic logic [7:0] m_strb(input logic [2:0] off, input logic [2:0] f3);
        logic [7:0] s;
        int o;
        s = 8'd0;
        o = int'(off);
        for (int i = 0; i < 8; i++)
            if (i >= o && i < o + nbytes(f3)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [2:0] off);
        logic [63:0] r;
        int o;
        r = 64'd0;
        o = int'(off);
        for (int i = 0; i < 8; i++)
            if (i >= o) r[8*i +: 8] = d[8*(i-o) +: 8];
        return r;
    endfunction

    // Gather bytes off..off+n-1 (missing bytes are 0), then extend
    function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] off, input logic [2:0] f3);
        logic [63:0] r;
        logic        sgn;
        int n;
        int o;
        r = 64'd0;
        n = nbytes(f3);
        o = int'(off);
        for (int j = 0; j < n; j++)
            if (o + j < 8) r[8*j +: 8] = rd[8*(o+j) +: 8];
        if (!f3[2]) begin
            sgn = r[8*n-1];
            for (int b = 8*n; b < 64; b++) r[b] = sgn;
        end
        return r;
    endfunction

    // Per-cycle compare against the model's expectations
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("stall", 64'(stall), 64'(e_stall));
            chk("mem_req", 64'(mem_req), 64'(e_req));
            chk("resp_valid", 64'(resp_valid), 64'(e_resp));
            if (e_req) begin
                chk("mem_we", 64'(mem_we), 64'(e_we));
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (e_resp) begin
                chk("err", 64'(err), 64'(e_err));
                chk("read_data", read_data, e_rdata);
            end
            if (mem_req) begin
                cap_req_cnt++;
                cap_we    = mem_we;
                cap_addr  = mem_addr;
                cap_wstrb = mem_wstrb;
                cap_wdata = mem_wdata;
            end
            if (resp_valid) begin
                cap_resp_c = cur_c;
                cap_err    = err;
                cap_rd     = read_data;
            end
        end
    end

    task automatic clear_caps();
        cap_req_cnt = 0;
        cap_resp_c  = -1;
        cap_err     = 1'bx;
        cap_we      = 1'bx;
        cap_rd      = 'x;
        cap_addr    = 'x;
        cap_wstrb   = 'x;
        cap_wdata   = 'x;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid      = 1'b0;
            MemRead        = 1'($urandom);
            MemWrite       = 1'($urandom);
            funct3         = 3'($urandom);
            memory_address = {$urandom, $urandom};
            write_data     = {$urandom, $urandom};
            mem_ack        = 1'($urandom);
            mem_rdata      = {$urandom, $urandom};
            e_ready = 1'b1; e_stall = 1'b0; e_req = 1'b0; e_resp = 1'b0;
            cur_c  = -1;
            cmp_en = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // One access: ack_at in 1..TO acks in that cycle, anything else never acks
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input logic [63:0] rdat, input int ack_at);
        logic [2:0]  off;
        int          n;
        logic        is_mem, trap, acked;
        int          kend, rc;
        logic [63:0] exp_rd;
        off    = addr[2:0];
        n      = nbytes(f3);
        is_mem = rd | wr;
        trap   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap   = is_mem && ((int'(off) % n) != 0);
`endif
        acked  = is_mem && !trap && ack_at >= 1 && ack_at <= int'(TO);
        if (!is_mem || trap) kend = 0;
        else if (acked)      kend = ack_at;
        else                 kend = int'(TO);
        rc     = kend + 1;
        exp_rd = (acked && !wr) ? m_load(rdat, off, f3) : 64'd0;
        clear_caps();
        MemRead = rd; MemWrite = wr; funct3 = f3;
        memory_address = addr; write_data = wd;
        for (int c = 0; c <= rc; c++) begin
            cur_c = c;
            if (c == 0)         req_valid = 1'b1;
            else if (c <= kend) req_valid = 1'($urandom_range(0, 1));
            else                req_valid = 1'b0;
            if (c >= 1 && c <= kend) mem_ack = acked && (c == ack_at);
            else                     mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = (c >= 1 && c <= kend && mem_ack) ? rdat : {$urandom, $urandom};
            e_ready = (c == 0);
            e_stall = (c <= kend);
            e_req   = (c >= 1 && c <= kend);
            e_resp  = (c == rc);
            e_err   = is_mem && !acked;
            e_rdata = exp_rd;
            e_we    = wr;
            e_addr  = {addr[63:3], 3'b000};
            e_wstrb = wr ? m_strb(off, f3) : 8'd0;
            e_wdata = m_wdata(wd, off);
            cmp_en  = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        t_rd, t_wr;
        logic [2:0]  t_f3;
        logic [63:0] t_addr;
        int          t_k;

        reset_n = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'd0; memory_address = 64'd0; write_data = 64'd0;
        mem_ack = 1'b0; mem_rdata = 64'd0;
        e_ready = 1'b1; e_stall = 1'b0; e_req = 1'b0; e_resp = 1'b0; e_err = 1'b0;
        e_we = 1'b0; e_rdata = 64'd0; e_addr = 64'd0; e_wdata = 64'd0; e_wstrb = 8'd0;
        cur_c = -1;
        clear_caps();
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_read_data", read_data, 64'd0);
        chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Pin the model against hand-computed values
        chk("pin_load_sb", m_load(64'h0000_80FF_0000_0000, 3'd5, 3'b000), 64'hFFFF_FFFF_FFFF_FF80);
        chk("pin_load_ub", m_load(64'h0000_80FF_0000_0000, 3'd5, 3'b100), 64'h80);
        chk("pin_strb_half", 64'(m_strb(3'd2, 3'b001)), 64'h0C);
        chk("pin_strb_trunc", 64'(m_strb(3'd6, 3'b010)), 64'hC0);
        chk("pin_load_mis", m_load(64'h8877_6655_4433_2211, 3'd6, 3'b010), 64'h8877);

        idle(1);

        // Store double at 0x40, ack in cycle 3
        run_txn(1'b0, 1'b1, 3'b011, 64'h40, 64'h1122_3344_5566_7788, 64'd0, 3);
        chk("sd_addr", cap_addr, 64'h40);
        chk("sd_wstrb", 64'(cap_wstrb), 64'hFF);
        chk("sd_we", 64'(cap_we), 64'd1);
        chk("sd_wdata", cap_wdata, 64'h1122_3344_5566_7788);
        chk("sd_resp_cycle", 64'(cap_resp_c), 64'd4);
        chk("sd_err", 64'(cap_err), 64'd0);

        // Signed and unsigned byte loads at 0x45
        run_txn(1'b1, 1'b0, 3'b000, 64'h45, 64'd0, 64'h0000_80FF_0000_0000, 1);
        chk("lb_data", cap_rd, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_resp_cycle", 64'(cap_resp_c), 64'd2);
        run_txn(1'b1, 1'b0, 3'b100, 64'h45, 64'd0, 64'h0000_80FF_0000_0000, 1);
        chk("lbu_data", cap_rd, 64'h80);

        // Store half at 0x12 (back-to-back after the load)
        run_txn(1'b0, 1'b1, 3'b001, 64'h12, 64'hBEEF, 64'd0, 2);
        chk("sh_addr", cap_addr, 64'h10);
        chk("sh_wstrb", 64'(cap_wstrb), 64'h0C);
        chk("sh_wdata", cap_wdata, 64'hBEEF_0000);

        // Timeout with no ack
        run_txn(1'b1, 1'b0, 3'b011, 64'h100, 64'd0, 64'd0, 0);
        chk("to_req_cycles", 64'(cap_req_cnt), 64'd4);
        chk("to_resp_cycle", 64'(cap_resp_c), 64'd5);
        chk("to_err", 64'(cap_err), 64'd1);
        chk("to_read_data", cap_rd, 64'd0);

        // Ack on the expiry cycle succeeds
        run_txn(1'b1, 1'b0, 3'b010, 64'h20, 64'd0, 64'h0000_0000_8000_0001, int'(TO));
        chk("late_ack_err", 64'(cap_err), 64'd0);
        chk("late_ack_data", cap_rd, 64'hFFFF_FFFF_8000_0001);
        chk("late_ack_resp_cycle", 64'(cap_resp_c), 64'd5);

        // Misaligned word load at 0x42
        run_txn(1'b1, 1'b0, 3'b010, 64'h42, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_err", 64'(cap_err), 64'd1);
        chk("mis_resp_cycle", 64'(cap_resp_c), 64'd1);
        chk("mis_req_cycles", 64'(cap_req_cnt), 64'd0);
`else
        chk("mis_req_cycles", 64'(cap_req_cnt), 64'd1);
        chk("mis_wstrb", 64'(cap_wstrb), 64'd0);
        chk("mis_data", cap_rd, 64'hFFFF_FFFF_BEEF_CAFE);
`endif

        // Reset in the middle of a REQ
        cmp_en = 1'b0;
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b011;
        memory_address = 64'h200; mem_ack = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_req_before_rst", 64'(mem_req), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_mem_req", 64'(mem_req), 64'd0);
        chk("rst_async_stall", 64'(stall), 64'd0);
        chk("rst_async_ready", 64'(req_ready), 64'd1);
        chk("rst_async_resp", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        run_txn(1'b1, 1'b0, 3'b011, 64'h8, 64'd0, 64'h0123_4567_89AB_CDEF, 2);
        chk("post_rst_data", cap_rd, 64'h0123_4567_89AB_CDEF);
        chk("post_rst_resp_cycle", 64'(cap_resp_c), 64'd3);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            t_k = int'($urandom_range(0, 9));
            t_rd = (t_k >= 1 && t_k <= 5) || t_k == 9;
            t_wr = (t_k >= 6);
            t_f3 = 3'($urandom);
            t_addr = {$urandom, $urandom};
            run_txn(t_rd, t_wr, t_f3, t_addr, {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(1, TO + 1)));
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
